// File: rtl/plus_asic_unlock_mmu.sv
// CPC Plus upstream control: ASIC unlock sequencer on the CRTC select port, MRER/RMR2 decode on the GA port.
// Build option: define PLUS_AUTO_UNLOCK_EN to leave reset with the ASIC already unlocked.
`timescale 1ns/1ps

// state    | meaning
// ST_IDLE  | waiting for a non-zero byte
// ST_NZ    | non-zero seen, waiting for the 00 sync byte
// ST_S0-13 | expecting key byte FF 77 B3 51 A8 D4 62 39 9C 46 2B 15 8A CD
// ST_FINAL | key complete; EE unlocks, anything else locks
module plus_asic_unlock_mmu #(
    parameter int FULL_DECODE = 0,
    parameter int SEQ_LEN     = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        IO_WR,
    output logic        asic_unlocked,
    output logic        int_enable,
    output logic [7:0]  mrer_val,
    output logic [4:0]  rmr2_val,
    output logic        rmr2_active,
    output logic        rmr2_now,
    output logic [2:0]  lower_rom_page,
    output logic        seq_err
);

`ifdef PLUS_AUTO_UNLOCK_EN
    localparam logic UNLOCK_RST = 1'b1;
`else
    localparam logic UNLOCK_RST = 1'b0;
`endif

    // The state list below hard-codes a 17-byte sequence (1 + 1 sync + 14 key + 1 final).
    if (SEQ_LEN != 17) begin : g_bad_seq_len
        $error("plus_asic_unlock_mmu: SEQ_LEN must be 17");
    end

    typedef enum logic [4:0] {
        ST_IDLE, ST_NZ,
        ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6,
        ST_S7, ST_S8, ST_S9, ST_S10, ST_S11, ST_S12, ST_S13,
        ST_FINAL
    } state_t;

    state_t state_q, state_d;
    logic   io_wr_q, wr_armed, wr_stb;
    logic   crtc_sel, ga_sel;
    logic   seq_err_d, lock_load;
    logic   rmr2_wr, mrer_wr;
    logic   unused_a;

    function automatic logic [7:0] key_byte(input state_t s);
        case (s)
            ST_S0:   key_byte = 8'hFF;
            ST_S1:   key_byte = 8'h77;
            ST_S2:   key_byte = 8'hB3;
            ST_S3:   key_byte = 8'h51;
            ST_S4:   key_byte = 8'hA8;
            ST_S5:   key_byte = 8'hD4;
            ST_S6:   key_byte = 8'h62;
            ST_S7:   key_byte = 8'h39;
            ST_S8:   key_byte = 8'h9C;
            ST_S9:   key_byte = 8'h46;
            ST_S10:  key_byte = 8'h2B;
            ST_S11:  key_byte = 8'h15;
            ST_S12:  key_byte = 8'h8A;
            ST_S13:  key_byte = 8'hCD;
            default: key_byte = 8'h00;
        endcase
    endfunction

    // wr_armed stops a write that was already high across reset from firing on release.
    assign wr_stb = IO_WR & ~io_wr_q & wr_armed;

    if (FULL_DECODE != 0) begin : g_full_decode
        assign crtc_sel = (A[15:8] == 8'hBC);
        assign ga_sel   = (A[15:8] == 8'h7F);
    end else begin : g_partial_decode
        assign crtc_sel = ~A[14] & (A[9:8] == 2'b00);
        assign ga_sel   = ~A[15] & A[14];
    end
    assign unused_a = ^{A[13:10], A[7:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        seq_err_d = 1'b0;
        lock_load = 1'b0;
        if (wr_stb && crtc_sel) begin
            case (state_q)
                ST_IDLE:  if (D != 8'h00) state_d = ST_NZ;
                ST_NZ:    if (D == 8'h00) state_d = ST_S0;
                ST_FINAL: begin
                    lock_load = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: begin
                    if (D == key_byte(state_q)) begin
                        state_d = state_t'(state_q + 5'd1);
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = (D == 8'h00) ? ST_S0 : ST_NZ;
                    end
                end
            endcase
        end
    end

    // RMR2 uses the lock state from before this edge; a locked 101x write falls back to MRER.
    assign rmr2_wr = wr_stb & ga_sel & (D[7:5] == 3'b101) & asic_unlocked;
    assign mrer_wr = wr_stb & ga_sel & (D[7:6] == 2'b10) & ~rmr2_wr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            io_wr_q       <= 1'b0;
            wr_armed      <= ~IO_WR;
            asic_unlocked <= UNLOCK_RST;
            mrer_val      <= 8'h00;
            int_enable    <= 1'b0;
            rmr2_val      <= 5'h00;
            rmr2_now      <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            io_wr_q  <= IO_WR;
            if (!IO_WR) wr_armed <= 1'b1;
            seq_err  <= seq_err_d;
            rmr2_now <= rmr2_wr;
            if (lock_load) asic_unlocked <= (D == 8'hEE);
            if (rmr2_wr) rmr2_val <= D[4:0];
            if (mrer_wr) begin
                mrer_val   <= D;
                int_enable <= D[4];
            end
        end
    end

    assign rmr2_active    = asic_unlocked & (rmr2_val[4:3] == 2'b11);
    assign lower_rom_page = rmr2_val[2:0];

endmodule
